// File: rtl/crc8_spi_rx_check.sv
`default_nettype none
// ============================================================================
//  Module   : crc8_spi_rx_check
//  Purpose  : SPI-side receive checker for the 24-bit data + CRC-8 link.
//             Oversamples SPI mode-0 pins in the clk domain and deserialises
//             32-bit frames (24 data bits, then 8 CRC bits, MSB first). It
//             runs CRC-8 (x^8+x^4+x^3+x^2+1) over the whole frame and reports
//             the payload with pass/fail status.
//  Ports    : clk, rst         - system clock (>= 4x sclk), sync active-high reset
//             spi_sclk/cs_n/mosi - asynchronous SPI pins
//             rx_data          - payload of the last completed 32-bit frame
//             rx_valid         - 1-cycle pulse, 32-bit frame completed
//             rx_crc_err       - 1-cycle pulse with rx_valid, CRC residue != 0
//             rx_len_err       - 1-cycle pulse, frame ended with count != 32
//             busy             - frame in progress (SHIFT or DONE)
//  Option   : `define CRC8_SPI_ERR_CNT_EN adds input err_cnt_clr and output
//             err_cnt[15:0], a saturating error-pulse counter.
//  Revision : 1.0 - initial release
// ============================================================================
module crc8_spi_rx_check #(
  parameter int         SYNC_STAGES = 2,      // 2..3
  parameter logic [7:0] CRC_INIT    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
`ifdef CRC8_SPI_ERR_CNT_EN
  input  logic        err_cnt_clr,
  output logic [15:0] err_cnt,
`endif
  output logic [23:0] rx_data,
  output logic        rx_valid,
  output logic        rx_crc_err,
  output logic        rx_len_err,
  output logic        busy
);

  localparam logic [7:0] CRC_POLY    = 8'h1D;
  localparam logic [5:0] FRAME_BITS  = 6'd32;
  localparam logic [5:0] BIT_CNT_MAX = 6'd63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Pin synchronisers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t      state, next_state;
  logic [5:0]  bit_cnt;
  logic [7:0]  lfsr, lfsr_nx;
  logic [31:0] sr;
  logic        valid_nx, crc_err_nx, len_err_nx;
  logic        crc_fb;

  // Serial CRC step for the bit currently on the synchronised mosi line.
  assign crc_fb  = lfsr[7] ^ mosi_s;
  assign lfsr_nx = {lfsr[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);

  always_comb begin
    next_state = state;
    valid_nx   = 1'b0;
    crc_err_nx = 1'b0;
    len_err_nx = 1'b0;
    case (state)
      IDLE:  if (cs_fall) next_state = SHIFT;
      SHIFT: if (cs_rise) next_state = DONE;
      DONE: begin
        // A correctly framed word leaves a zero residue in the LFSR.
        next_state = IDLE;
        if (bit_cnt == FRAME_BITS) begin
          valid_nx   = 1'b1;
          crc_err_nx = (lfsr != 8'h00);
        end else begin
          len_err_nx = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 6'd0;
      lfsr       <= CRC_INIT;
      sr         <= 32'd0;
      rx_data    <= 24'd0;
      rx_valid   <= 1'b0;
      rx_crc_err <= 1'b0;
      rx_len_err <= 1'b0;
    end else begin
      state      <= next_state;
      rx_valid   <= valid_nx;
      rx_crc_err <= crc_err_nx;
      rx_len_err <= len_err_nx;
      if (valid_nx) rx_data <= sr[31:8];

      if (state == IDLE && cs_fall) begin
        lfsr    <= CRC_INIT;
        bit_cnt <= 6'd0;
        sr      <= 32'd0;
      end

      // Stays in SHIFT for this cycle even when cs_rise coincides, so the
      // final bit is captured before the frame closes.
      if (state == SHIFT && sclk_rise) begin
        sr   <= {sr[30:0], mosi_s};
        lfsr <= lfsr_nx;
        if (bit_cnt != BIT_CNT_MAX) bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef CRC8_SPI_ERR_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating error counter; clear has priority over increment.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || err_cnt_clr) begin
      err_cnt <= 16'd0;
    end else if ((rx_crc_err || rx_len_err) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc8_spi_rx_check.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc8_spi_rx_check
//  Purpose  : Directed self-checking bench for crc8_spi_rx_check. Drives
//             SPI mode-0 frames at sclk = clk/8 and checks pulses, payload,
//             CRC status, length errors, reset behaviour and latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crc8_spi_rx_check;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [23:0] rx_data;
  logic        rx_valid, rx_crc_err, rx_len_err, busy;
`ifdef CRC8_SPI_ERR_CNT_EN
  logic        err_cnt_clr = 1'b0;
  logic [15:0] err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Pulse counters maintained by the monitor below.
  int          n_valid = 0, n_crc = 0, n_len = 0, n_orphan = 0;
  logic [23:0] last_data = 24'd0;

  crc8_spi_rx_check #(.SYNC_STAGES(SYNC), .CRC_INIT(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
`ifdef CRC8_SPI_ERR_CNT_EN
    .err_cnt_clr(err_cnt_clr),
    .err_cnt    (err_cnt),
`endif
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_crc_err (rx_crc_err),
    .rx_len_err (rx_len_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid   <= n_valid + 1;
      last_data <= rx_data;
    end
    if (rx_crc_err)              n_crc    <= n_crc + 1;
    if (rx_crc_err && !rx_valid) n_orphan <= n_orphan + 1;
    if (rx_len_err)              n_len    <= n_len + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC over a 24-bit payload (init 0xFF, poly 0x1D, MSB first).
  function automatic logic [7:0] crc8_of(input logic [23:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    for (int i = 23; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
    end
    return c;
  endfunction

  // Clock n bits (MSB of the n-bit field first); cs_n is left untouched.
  task automatic clock_bits(input logic [63:0] bits, input int n, input logic last_with_cs);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      #40;
      if (i == n / 2) check("busy_mid_frame", {31'd0, busy}, 32'd1);
      spi_sclk = 1'b1;
      if (last_with_cs && i == 0) spi_cs_n = 1'b1;
      #40;
      spi_sclk = 1'b0;
    end
  endtask

  // mode 0: normal release; mode 1: cs_n rises with the last sclk rise;
  // mode 2: cs_n rises just after a clk edge and the rx_valid latency is
  // measured (returns as soon as rx_valid is seen, or after a bound).
  task automatic send_frame(input logic [63:0] bits, input int n, input int mode, output int lat);
    lat = 99;
    spi_cs_n = 1'b0;
    #80;
    clock_bits(bits, n, mode == 1);
    if (mode == 0) begin
      #40;
      spi_cs_n = 1'b1;
      #200;
    end else if (mode == 1) begin
      #200;
    end else begin
      #40;
      @(posedge clk);
      #1;
      spi_cs_n = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk);
        #1;
        if (rx_valid) begin
          lat = c;
          break;
        end
      end
    end
  endtask

  initial begin
    int          lat;
    logic [23:0] d;

    // ---------------- reset state ----------------
    #50;
    check("rst_rx_data",    {8'd0, rx_data},         32'd0);
    check("rst_rx_valid",   {31'd0, rx_valid},       32'd0);
    check("rst_rx_crc_err", {31'd0, rx_crc_err},     32'd0);
    check("rst_rx_len_err", {31'd0, rx_len_err},     32'd0);
    check("rst_busy",       {31'd0, busy},           32'd0);
    rst = 1'b0;
    #100;

    // ---------------- good all-zero frame, CRC 0x0E ----------------
    check("crc_model_zero", {24'd0, crc8_of(24'h000000)}, 32'h0E);
    send_frame({32'd0, 24'h000000, 8'h0E}, 32, 0, lat);
    check("zero_valid_cnt", n_valid, 1);
    check("zero_crc_cnt",   n_crc,   0);
    check("zero_len_cnt",   n_len,   0);
    check("zero_data",      {8'd0, rx_data}, 32'd0);
    check("zero_busy_idle", {31'd0, busy},   32'd0);

    // ---------------- same frame, bad CRC 0x0F ----------------
    send_frame({32'd0, 24'h000000, 8'h0F}, 32, 0, lat);
    check("badcrc_valid_cnt", n_valid, 2);
    check("badcrc_crc_cnt",   n_crc,   1);
    check("badcrc_orphan",    n_orphan, 0);
    check("badcrc_data",      {8'd0, rx_data}, 32'd0);

    // ---------------- good non-trivial payload ----------------
    d = 24'hA5C33C;
    send_frame({32'd0, d, crc8_of(d)}, 32, 0, lat);
    check("good1_valid_cnt", n_valid, 3);
    check("good1_crc_cnt",   n_crc,   1);
    check("good1_data",      {8'd0, rx_data}, {8'd0, d});

    // ---------------- short (20) and long (33) frames ----------------
    send_frame({44'd0, 20'hABCDE}, 20, 0, lat);
    check("short_len_cnt",   n_len,   1);
    check("short_valid_cnt", n_valid, 3);
    check("short_data_hold", {8'd0, rx_data}, 32'h00A5C33C);
    send_frame({31'd0, 24'h000000, 8'h0E, 1'b0}, 33, 0, lat);
    check("long_len_cnt",    n_len,   2);
    check("long_valid_cnt",  n_valid, 3);
    check("long_data_hold",  {8'd0, rx_data}, 32'h00A5C33C);

    // ---------------- zero-length frame ----------------
    spi_cs_n = 1'b0;
    #80;
    spi_cs_n = 1'b1;
    #200;
    check("zero_len_len_cnt", n_len,   3);
    check("zero_len_valid",   n_valid, 3);

    // ---------------- reset mid-frame, then good frame ----------------
    spi_cs_n = 1'b0;
    #80;
    clock_bits({32'd0, 24'hFFFFFF, 8'hAA}, 12, 1'b0);
    rst = 1'b1;
    #50;
    check("midrst_busy",    {31'd0, busy},   32'd0);
    check("midrst_rx_data", {8'd0, rx_data}, 32'd0);
    spi_cs_n = 1'b1;
    #50;
    rst = 1'b0;
    #100;
    d = 24'h123456;
    send_frame({32'd0, d, crc8_of(d)}, 32, 0, lat);
    check("postrst_valid_cnt", n_valid, 4);
    check("postrst_len_cnt",   n_len,   3);
    check("postrst_data",      {8'd0, rx_data}, {8'd0, d});

    // ---------------- sclk activity with cs_n high ----------------
    spi_mosi = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #40 spi_sclk = 1'b1;
      #40 spi_sclk = 1'b0;
    end
    #80;
    check("idle_sclk_busy", {31'd0, busy}, 32'd0);
    d = 24'h0F0F0F;
    send_frame({32'd0, d, crc8_of(d)}, 32, 0, lat);
    check("idle_sclk_valid_cnt", n_valid, 5);
    check("idle_sclk_len_cnt",   n_len,   3);
    check("idle_sclk_data",      {8'd0, rx_data}, {8'd0, d});

    // ---------------- last sclk rise coincident with cs_n rise ----------------
    d = 24'h800001;
    send_frame({32'd0, d, crc8_of(d)}, 32, 1, lat);
    check("coinc_valid_cnt", n_valid, 6);
    check("coinc_crc_cnt",   n_crc,   1);
    check("coinc_len_cnt",   n_len,   3);
    check("coinc_data",      {8'd0, rx_data}, {8'd0, d});

    // ---------------- rx_valid latency from cs_n pin rise ----------------
    d = 24'h00FF00;
    send_frame({32'd0, d, crc8_of(d)}, 32, 2, lat);
    check("latency", lat, SYNC + 2);
    #200;
    check("lat_data",      {8'd0, last_data}, {8'd0, d});
    check("lat_valid_cnt", n_valid, 7);

`ifdef CRC8_SPI_ERR_CNT_EN
    // ---------------- error counter ----------------
    err_cnt_clr = 1'b1;
    #10;
    err_cnt_clr = 1'b0;
    #20;
    check("errcnt_clr", {16'd0, err_cnt}, 32'd0);
    for (int k = 0; k < 3; k++)
      send_frame({32'd0, 24'h000000, 8'h0F}, 32, 0, lat);
    check("errcnt_three", {16'd0, err_cnt}, 32'd3);
    // Clear lands on the same edge as the 4th error's increment.
    send_frame({32'd0, 24'h000000, 8'h0F}, 32, 2, lat);
    err_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    err_cnt_clr = 1'b0;
    #100;
    check("errcnt_clr_wins", {16'd0, err_cnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crc8_spi_rx_check.md
Name: crc8_spi_rx_check

Overview:
SPI-side receive checker, the other end of the 24-bit data plus CRC-8 SPI link.
- Deserialises 32-bit frames from an external SPI master: 24 data bits followed by 8 CRC bits, MSB first, SPI mode 0.
- Recomputes CRC-8 (x^8+x^4+x^3+x^2+1, init 0xFF) serially over the whole frame.
- Delivers the data word with pass/fail status to the register-file side.
- All SPI pins are oversampled in the system clock domain.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on spi_sclk, spi_cs_n and spi_mosi (legal range 2..3).
- CRC_INIT, 8'hFF, LFSR value loaded at each frame start.

Ports:
- clk  input  1  system clock; must be at least 4x spi_sclk frequency.
- rst  input  1  synchronous, active-high reset.
- spi_sclk  input  1  SPI clock, asynchronous.
- spi_cs_n  input  1  SPI chip select, active low, asynchronous.
- spi_mosi  input  1  SPI data, asynchronous.
- rx_data  output  24  last accepted frame payload.
- rx_valid  output  1  one-cycle pulse: a 32-bit frame completed.
- rx_crc_err  output  1  one-cycle pulse, coincident with rx_valid, when the CRC check failed.
- rx_len_err  output  1  one-cycle pulse: frame aborted with a bit count other than 32.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_crc_err=0, rx_len_err=0, busy=0, FSM=IDLE, bit_cnt=0, lfsr=CRC_INIT.
- Synchronisers reset to spi_sclk=0, spi_cs_n=1, spi_mosi=0.
- Edge detection uses the last synchronised stage plus one delay register: sclk_rise, cs_fall, cs_rise.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On cs_fall: lfsr<=CRC_INIT, bit_cnt<=0, shift register cleared, go to SHIFT.
  - sclk edges while cs_n is high are ignored.
- SHIFT:
  - On each sclk_rise, d = synchronised mosi.
  - Shift register <= {sr[30:0], d}.
  - fb = lfsr[7]^d; lfsr <= {lfsr[6:0],1'b0} ^ (fb ? 8'h1D : 8'h00).
  - bit_cnt increments and saturates at 63.
  - On cs_rise go to DONE, whether or not an sclk_rise occurs in the same cycle. If both occur, the bit is taken first.
- DONE (single cycle), then IDLE:
  - If bit_cnt==32: rx_data<=sr[31:8], rx_valid=1, rx_crc_err=(lfsr!=0). Residue check: a correct frame leaves the LFSR at 0.
  - Otherwise (fewer or more than 32 bits): rx_len_err=1. rx_data and rx_valid are unchanged.
- Latency: rx_valid is asserted 2 cycles after the synchronised cs_n rise is registered, i.e. SYNC_STAGES+2 clk cycles after the pin rises.
- rx_data holds its value until the next valid frame. It is updated even on a CRC error; the consumer gates on rx_crc_err.
- busy=1 in SHIFT and DONE.
- cs_fall seen in DONE: ignored. A new frame requires cs_n high for at least 2 synchronised cycles.
- rst mid-frame: all state returns to reset values immediately. The remainder of the frame is ignored until the next cs_fall.
- Zero-length frame (cs toggle with no sclk): rx_len_err pulse.

Optional Feature:
- Macro CRC8_SPI_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [15:0].
  - err_cnt increments on each rx_crc_err or rx_len_err pulse and saturates at 16'hFFFF.
  - Cleared by rst, and by a one-cycle input err_cnt_clr.
  - If increment and clear coincide, clear wins.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- Frame data 24'h000000, CRC 8'h0E (32 bits, sclk = clk/8) -> rx_valid pulse, rx_data=24'h000000, rx_crc_err=0.
- Same frame with CRC byte 8'h0F -> rx_valid=1, rx_crc_err=1, rx_data=24'h000000.
- cs_n released after 20 bits, then after 33 bits -> two rx_len_err pulses, no rx_valid, rx_data keeps its prior value.
- rst asserted after bit 12, released, then a full good frame -> exactly one rx_valid with correct data, no len_err.
- sclk toggles with cs_n high, then a good frame -> only the framed bits are captured, rx_valid once.
- With CRC8_SPI_ERR_CNT_EN defined: 3 bad-CRC frames -> err_cnt=3; err_cnt_clr coinciding with a 4th error -> err_cnt=0.
